axi_burst_master: RTL

Parametrised AXI4 burst master used as the traffic generator in the AMBA AXI testbench environment. It accepts a single read or write command and issues one INCR burst of programmable length and width. Write data is an incrementing pattern. Read data is captured into an internal buffer that can be read back, and the block reports per-transaction status. It sits on the master side of the AXI interface and faces the slave or interconnect under test.

---
 rtl/axi_burst_master_if.sv | 65 ++++++
 rtl/axi_burst_master.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle between axi_burst_master and the slave/interconnect under test.
// Carries the five AXI4 channels (AR, R, AW, W, B); clock and reset stay outside
// the bundle.
//   master modport : drives address/control, write data and ready for R/B
//   slave modport  : drives address ready, read data/response and write response
interface axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 burst master / traffic generator. Accepts one read or write command at a
// time and issues a single INCR burst. Write data is pattern + beat; read data is
// captured into a buffer readable through buf_idx/buf_data.
//
// Ports:
//   aclk, areset_n          clock, asynchronous active-low reset
//   start_read/start_write  command requests, sampled in IDLE (read wins)
//   cmd_addr/cmd_len/cmd_pattern  burst start address, beats-1, write base value
//   busy, done, err, beat_cnt     status (err: 0 OK, 1 resp error, 2 rlast mismatch, 3 4K)
//   buf_idx -> buf_data     combinational read-buffer access
//   axi                     AXI4 master modport
//
// Optional feature macro: AXI_BURST_MASTER_4K_CHECK_EN
//   When defined, commands whose burst crosses a 4 KB boundary are rejected in
//   IDLE with err=3 and no bus activity.
//
// state  | meaning
// -------+--------------------------------------------
// IDLE   | waiting for a command
// RADDR  | arvalid high, waiting for arready
// RDATA  | rready high, capturing read beats
// WADDR  | awvalid high, waiting for awready
// WDATA  | wvalid high, streaming pattern + beat
// WRESP  | bready high, waiting for bvalid
module axi_burst_master #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BEATS = 16,
    localparam int IW        = $clog2(MAX_BEATS),
    localparam int BW        = IW + 1
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              start_read,
    input  logic              start_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_pattern,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [BW-1:0]     beat_cnt,
    input  logic [IW-1:0]     buf_idx,
    output logic [DATA_W-1:0] buf_data,
    axi_burst_master_if.master axi
);

    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W/8));

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     len_q;
    logic [DATA_W-1:0] pattern_q;
    logic [BW-1:0]     beat;
    logic [1:0]        err_q;
    logic              done_q;
    logic [DATA_W-1:0] rd_buf [MAX_BEATS];

    logic [BW-1:0]     eff_len;
    logic              cmd_req;
    logic              cross_4k;
    logic              wlast_i;

    // Length is clamped so the read buffer can never be overrun.
    always_comb begin
        if (32'(cmd_len) > 32'(MAX_BEATS - 1))
            eff_len = BW'(MAX_BEATS - 1);
        else
            eff_len = BW'(cmd_len);
    end

    assign cmd_req = start_read | start_write;
    assign wlast_i = (beat == len_q);

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    logic [31:0] end_off;
    assign end_off  = 32'(cmd_addr[11:0]) + (32'(eff_len) + 32'd1) * 32'(DATA_W/8);
    assign cross_4k = (end_off > 32'd4096);
`else
    assign cross_4k = 1'b0;
`endif

    // State register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) state <= S_IDLE;
        else           state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (cmd_req && !cross_4k)
                    state_n = start_read ? S_RADDR : S_WADDR;
            end
            S_RADDR: if (axi.arready)               state_n = S_RDATA;
            S_RDATA: if (axi.rvalid && axi.rlast)   state_n = S_IDLE;
            S_WADDR: if (axi.awready)               state_n = S_WDATA;
            S_WDATA: if (axi.wready && wlast_i)     state_n = S_WRESP;
            S_WRESP: if (axi.bvalid)                state_n = S_IDLE;
            default:                                state_n = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state != S_IDLE);
        axi.arvalid = (state == S_RADDR);
        axi.rready  = (state == S_RDATA);
        axi.awvalid = (state == S_WADDR);
        axi.wvalid  = (state == S_WDATA);
        axi.wlast   = (state == S_WDATA) && wlast_i;
        axi.bready  = (state == S_WRESP);
        axi.araddr  = addr_q;
        axi.awaddr  = addr_q;
        axi.arlen   = 8'(len_q);
        axi.awlen   = 8'(len_q);
        axi.arsize  = AXSIZE;
        axi.awsize  = AXSIZE;
        axi.arburst = 2'b01;
        axi.awburst = 2'b01;
        axi.wdata   = pattern_q + DATA_W'(beat);
        axi.wstrb   = '1;
    end

    // Command latch, beat counting, status and read buffer
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            addr_q    <= '0;
            len_q     <= '0;
            pattern_q <= '0;
            beat      <= '0;
            err_q     <= 2'd0;
            done_q    <= 1'b0;
            for (int i = 0; i < MAX_BEATS; i++) rd_buf[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_req) begin
                        addr_q    <= cmd_addr;
                        len_q     <= eff_len;
                        pattern_q <= cmd_pattern;
                        beat      <= '0;
                        if (cross_4k) begin
                            err_q  <= 2'd3;
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 2'd0;
                        end
                    end
                end
                S_RDATA: begin
                    if (axi.rvalid) begin
                        // Beats past the announced length are dropped, not stored.
                        if (beat <= len_q) begin
                            rd_buf[beat[IW-1:0]] <= axi.rdata;
                            beat                 <= beat + 1'b1;
                        end
                        // A response error outranks a framing error, even one
                        // already recorded on an earlier beat.
                        if (axi.rresp != 2'b00)
                            err_q <= 2'd1;
                        else if (err_q != 2'd1 &&
                                 ((axi.rlast && beat != len_q) || beat > len_q))
                            err_q <= 2'd2;
                        if (axi.rlast) done_q <= 1'b1;
                    end
                end
                S_WDATA: begin
                    if (axi.wready) beat <= beat + 1'b1;
                end
                S_WRESP: begin
                    if (axi.bvalid) begin
                        if (axi.bresp != 2'b00) err_q <= 2'd1;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign beat_cnt = beat;
    assign buf_data = rd_buf[buf_idx];

endmodule
